// File: rtl/ddr3_dma_arbiter.sv
// ============================================================================
// ddr3_dma_arbiter : two-requester (write/read) arbiter for a DDR3 app port.
// Optional command counters: define DDR3_DMA_ARB_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module ddr3_dma_arbiter #(
  parameter int BURST_MAX = 16,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  input  logic              wr_app_en,
  input  logic [ADDR_W-1:0] wr_app_addr,
  input  logic [DATA_W-1:0] wr_app_wdf_data,
  input  logic              wr_app_wdf_wren,
  input  logic              wr_app_wdf_end,
  output logic              wr_app_rdy,
  output logic              wr_app_wdf_rdy,
  input  logic              rd_app_en,
  input  logic [ADDR_W-1:0] rd_app_addr,
  output logic              rd_app_rdy,
  output logic [DATA_W-1:0] rd_app_rd_data,
  output logic              rd_app_rd_data_valid,
  output logic              grant_wr,
  output logic              grant_rd,
  output logic [31:0]       wr_cmd_cnt,
  output logic [31:0]       rd_cmd_cnt
);

  localparam int                 c_CNT_W    = $clog2(BURST_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_QUOTA_M1 = c_CNT_W'(BURST_MAX - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_grant_wr;
  logic               r_grant_rd;
  logic               r_last_wr;
  logic [c_CNT_W-1:0] r_beat_cnt;
  logic               w_beat;
  logic               w_at_quota;

  assign grant_wr = r_grant_wr;
  assign grant_rd = r_grant_rd;

  // Everything toward the DDR side is gated by calibration so a falling
  // calib cannot leak a beat in the cycle before the FSM drops to IDLE.
  assign app_en         = init_calib_complete &
                          ((r_grant_wr & wr_app_en) | (r_grant_rd & rd_app_en));
  assign app_addr       = r_grant_rd ? rd_app_addr : wr_app_addr;
  assign app_cmd        = r_grant_rd ? 3'b001 : 3'b000;
  assign app_wdf_data   = wr_app_wdf_data;
  assign app_wdf_wren   = init_calib_complete & r_grant_wr & wr_app_wdf_wren;
  assign app_wdf_end    = init_calib_complete & r_grant_wr & wr_app_wdf_end;
  assign wr_app_rdy     = init_calib_complete & r_grant_wr & app_rdy;
  assign wr_app_wdf_rdy = init_calib_complete & r_grant_wr & app_wdf_rdy;
  assign rd_app_rdy     = init_calib_complete & r_grant_rd & app_rdy;

  assign rd_app_rd_data       = app_rd_data;
  assign rd_app_rd_data_valid = app_rd_data_valid;

  assign w_beat     = app_en & app_rdy;
  assign w_at_quota = (r_beat_cnt == c_QUOTA_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant_wr <= 1'b0;
      r_grant_rd <= 1'b0;
      r_last_wr  <= 1'b1;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init_calib_complete && (wr_app_en || rd_app_en)) begin
            r_beat_cnt <= '0;
            // On a tie the side not served last wins.
            if (wr_app_en && (!rd_app_en || !r_last_wr)) begin
              r_state    <= S_WR;
              r_grant_wr <= 1'b1;
            end else begin
              r_state    <= S_RD;
              r_grant_rd <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (!init_calib_complete || !wr_app_en) begin
            r_state    <= S_IDLE;
            r_grant_wr <= 1'b0;
            r_last_wr  <= 1'b1;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            if (w_at_quota) begin
              r_beat_cnt <= '0;
              if (rd_app_en) begin
                r_state    <= S_TURN;
                r_grant_wr <= 1'b0;
                r_last_wr  <= 1'b1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + c_ONE;
            end
          end
        end
        S_RD: begin
          if (!init_calib_complete || !rd_app_en) begin
            r_state    <= S_IDLE;
            r_grant_rd <= 1'b0;
            r_last_wr  <= 1'b0;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            if (w_at_quota) begin
              r_beat_cnt <= '0;
              if (wr_app_en) begin
                r_state    <= S_TURN;
                r_grant_rd <= 1'b0;
                r_last_wr  <= 1'b0;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + c_ONE;
            end
          end
        end
        S_TURN: begin
          r_beat_cnt <= '0;
          if (!init_calib_complete) begin
            r_state <= S_IDLE;
          end else if (r_last_wr) begin
            r_state    <= S_RD;
            r_grant_rd <= 1'b1;
          end else begin
            r_state    <= S_WR;
            r_grant_wr <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_grant_wr <= 1'b0;
          r_grant_rd <= 1'b0;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef DDR3_DMA_ARB_STATS_EN
  logic [31:0] r_wr_cmd_cnt;
  logic [31:0] r_rd_cmd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cmd_cnt <= 32'd0;
      r_rd_cmd_cnt <= 32'd0;
    end else begin
      if (w_beat && r_grant_wr) r_wr_cmd_cnt <= r_wr_cmd_cnt + 32'd1;
      if (w_beat && r_grant_rd) r_rd_cmd_cnt <= r_rd_cmd_cnt + 32'd1;
    end
  end

  assign wr_cmd_cnt = r_wr_cmd_cnt;
  assign rd_cmd_cnt = r_rd_cmd_cnt;
`else
  assign wr_cmd_cnt = 32'd0;
  assign rd_cmd_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr3_dma_arbiter.sv
// ============================================================================
// tb_ddr3_dma_arbiter : self-checking bench for ddr3_dma_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr3_dma_arbiter;

  localparam int BM = 16;
  localparam int AW = 30;
  localparam int DW = 512;

  localparam int O_NONE = 0;
  localparam int O_WR   = 1;
  localparam int O_RD   = 2;
  localparam int O_HAND = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_calib_complete;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          wr_app_en;
  logic [AW-1:0] wr_app_addr;
  logic [DW-1:0] wr_app_wdf_data;
  logic          wr_app_wdf_wren;
  logic          wr_app_wdf_end;
  logic          wr_app_rdy;
  logic          wr_app_wdf_rdy;
  logic          rd_app_en;
  logic [AW-1:0] rd_app_addr;
  logic          rd_app_rdy;
  logic [DW-1:0] rd_app_rd_data;
  logic          rd_app_rd_data_valid;
  logic          grant_wr;
  logic          grant_rd;
  logic [31:0]   wr_cmd_cnt;
  logic [31:0]   rd_cmd_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, beats used of the quota, tie history.
  int          m_owner;
  int          m_beats;
  bit          m_last_wr;
  logic [31:0] m_wr_total;
  logic [31:0] m_rd_total;

  ddr3_dma_arbiter #(.BURST_MAX(BM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .wr_app_en(wr_app_en), .wr_app_addr(wr_app_addr), .wr_app_wdf_data(wr_app_wdf_data),
    .wr_app_wdf_wren(wr_app_wdf_wren), .wr_app_wdf_end(wr_app_wdf_end),
    .wr_app_rdy(wr_app_rdy), .wr_app_wdf_rdy(wr_app_wdf_rdy),
    .rd_app_en(rd_app_en), .rd_app_addr(rd_app_addr), .rd_app_rdy(rd_app_rdy),
    .rd_app_rd_data(rd_app_rd_data), .rd_app_rd_data_valid(rd_app_rd_data_valid),
    .grant_wr(grant_wr), .grant_rd(grant_rd),
    .wr_cmd_cnt(wr_cmd_cnt), .rd_cmd_cnt(rd_cmd_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_calib_complete = 1'b1;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    wr_app_en = 1'b0; wr_app_addr = '0; wr_app_wdf_data = '0;
    wr_app_wdf_wren = 1'b0; wr_app_wdf_end = 1'b0;
    rd_app_en = 1'b0; rd_app_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_owner = O_NONE; m_beats = 0; m_last_wr = 1'b1;
    m_wr_total = 32'd0; m_rd_total = 32'd0;
  endtask

  // Advance the model across one clock edge from the current inputs.
  task automatic model_step();
    bit beat;
    beat = init_calib_complete && app_rdy &&
           ((m_owner == O_WR && wr_app_en) || (m_owner == O_RD && rd_app_en));
    if (beat && m_owner == O_WR) m_wr_total = m_wr_total + 32'd1;
    if (beat && m_owner == O_RD) m_rd_total = m_rd_total + 32'd1;
    case (m_owner)
      O_NONE: if (init_calib_complete && (wr_app_en || rd_app_en)) begin
        m_beats = 0;
        if (wr_app_en && rd_app_en) m_owner = m_last_wr ? O_RD : O_WR;
        else m_owner = wr_app_en ? O_WR : O_RD;
      end
      O_WR, O_RD: begin
        bit own_en, other_en;
        own_en   = (m_owner == O_WR) ? wr_app_en : rd_app_en;
        other_en = (m_owner == O_WR) ? rd_app_en : wr_app_en;
        if (!init_calib_complete || !own_en) begin
          m_last_wr = (m_owner == O_WR);
          m_owner = O_NONE; m_beats = 0;
        end else if (beat) begin
          m_beats++;
          if (m_beats == BM) begin
            m_beats = 0;
            if (other_en) begin
              m_last_wr = (m_owner == O_WR);
              m_owner = O_HAND;
            end
          end
        end
      end
      default: begin
        m_beats = 0;
        if (!init_calib_complete) m_owner = O_NONE;
        else m_owner = m_last_wr ? O_RD : O_WR;
      end
    endcase
  endtask

  task automatic test_reset();
    idle_inputs();
    wr_app_en = 1'b1; rd_app_en = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    wr_app_wdf_wren = 1'b1; wr_app_wdf_end = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant_wr !== 1'b0 || grant_rd !== 1'b0) begin
      errors++; $display("FAIL reset_grants got %b%b want 00", grant_wr, grant_rd); end
    checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin
      errors++; $display("FAIL reset_app got en=%b wren=%b end=%b want 0", app_en, app_wdf_wren, app_wdf_end); end
    checks++; if (wr_app_rdy !== 1'b0 || wr_app_wdf_rdy !== 1'b0 || rd_app_rdy !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b%b want 000", wr_app_rdy, wr_app_wdf_rdy, rd_app_rdy); end
    checks++; if (wr_cmd_cnt !== 32'd0 || rd_cmd_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", wr_cmd_cnt, rd_cmd_cnt); end
    do_reset();
  endtask

  task automatic test_calib_gate();
    bit bad;
    do_reset();
    init_calib_complete = 1'b0; wr_app_en = 1'b1; app_rdy = 1'b1; wr_app_wdf_wren = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (app_en !== 1'b0 || grant_wr !== 1'b0 || wr_app_rdy !== 1'b0 || app_wdf_wren !== 1'b0) bad = 1'b1;
      next_cycle();
    end
    checks++; if (bad) begin
      errors++; $display("FAIL calib_low_gate got activity want app_en=0 grant_wr=0"); end
    init_calib_complete = 1'b1;
    @(negedge clk);
    checks++; if (grant_wr !== 1'b0) begin
      errors++; $display("FAIL calib_rise_same_cycle got grant_wr=%b want 0", grant_wr); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant_wr !== 1'b1 || app_en !== 1'b1 || app_cmd !== 3'b000) begin
      errors++; $display("FAIL calib_rise_grant got grant_wr=%b app_en=%b cmd=%0d want 1 1 0", grant_wr, app_en, app_cmd); end
  endtask

  // Contention with app_rdy=1: period of 2*BM+2 cycles, read first.
  task automatic test_tie_pattern();
    bit exp_wr, exp_rd;
    int p;
    do_reset();
    wr_app_en = 1'b1; rd_app_en = 1'b1; app_rdy = 1'b1;
    for (int c = 0; c < 3 * (2 * BM + 2); c++) begin
      @(negedge clk);
      exp_wr = 1'b0; exp_rd = 1'b0;
      if (c > 0) begin
        p = (c - 1) % (2 * BM + 2);
        exp_rd = (p < BM);
        exp_wr = (p > BM) && (p <= 2 * BM);
      end
      checks++; if (grant_wr !== exp_wr || grant_rd !== exp_rd) begin
        errors++; $display("FAIL tie_grant c=%0d got %b%b want %b%b", c, grant_wr, grant_rd, exp_wr, exp_rd); end
      checks++; if (app_en !== (exp_wr | exp_rd) || app_cmd !== (exp_rd ? 3'b001 : 3'b000)) begin
        errors++; $display("FAIL tie_cmd c=%0d got en=%b cmd=%0d want en=%b", c, app_en, app_cmd, exp_wr | exp_rd); end
      next_cycle();
    end
  endtask

  task automatic test_single_stream();
    int beats;
    bit bad;
    do_reset();
    wr_app_en = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    next_cycle();
    beats = 0; bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wr_app_addr = AW'($urandom); wr_app_wdf_data = rnd_data();
      wr_app_wdf_wren = $urandom_range(0, 1); wr_app_wdf_end = $urandom_range(0, 1);
      @(negedge clk);
      if (grant_wr !== 1'b1 || grant_rd !== 1'b0 || app_cmd !== 3'b000) bad = 1'b1;
      if (app_en === 1'b1 && app_rdy === 1'b1) beats++;
      checks++; if (app_addr !== wr_app_addr || app_wdf_data !== wr_app_wdf_data ||
                    app_wdf_wren !== wr_app_wdf_wren || app_wdf_end !== wr_app_wdf_end ||
                    wr_app_wdf_rdy !== 1'b1) begin
        errors++; $display("FAIL stream_route c=%0d got addr=%h wren=%b end=%b want addr=%h wren=%b end=%b",
                           c, app_addr, app_wdf_wren, app_wdf_end, wr_app_addr, wr_app_wdf_wren, wr_app_wdf_end); end
      next_cycle();
    end
    checks++; if (bad) begin
      errors++; $display("FAIL stream_grant got grant/cmd deviation want grant_wr=1 cmd=0"); end
    checks++; if (beats != 40) begin
      errors++; $display("FAIL stream_beats got %0d want 40", beats); end
    wr_app_en = 1'b0;
    @(negedge clk);
    checks++; if (grant_wr !== 1'b1 || app_en !== 1'b0) begin
      errors++; $display("FAIL stream_release_cycle got grant_wr=%b app_en=%b want 1 0", grant_wr, app_en); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant_wr !== 1'b0) begin
      errors++; $display("FAIL stream_idle got grant_wr=%b want 0", grant_wr); end
  endtask

  // Quota counts accepted beats, not cycles.
  task automatic test_rdy_toggle();
    int beats, cyc;
    do_reset();
    wr_app_en = 1'b1;
    next_cycle();
    rd_app_en = 1'b1;
    beats = 0; cyc = 0;
    while (cyc < 200) begin
      app_rdy = (cyc % 2 == 0);
      @(negedge clk);
      if (grant_wr !== 1'b1) break;
      if (app_en === 1'b1 && app_rdy === 1'b1) beats++;
      cyc++;
      next_cycle();
    end
    checks++; if (beats != BM || cyc != 2 * BM - 1) begin
      errors++; $display("FAIL toggle_quota got beats=%0d cycles=%0d want %0d %0d", beats, cyc, BM, 2 * BM - 1); end
    checks++; if (grant_rd !== 1'b0) begin
      errors++; $display("FAIL toggle_turn got grant_rd=%b want 0", grant_rd); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant_rd !== 1'b1 || app_cmd !== 3'b001) begin
      errors++; $display("FAIL toggle_rd got grant_rd=%b cmd=%0d want 1 1", grant_rd, app_cmd); end
  endtask

  task automatic test_random();
    bit ew, er, een;
    logic [31:0] xw, xr;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) == 0) wr_app_en = ~wr_app_en;
      if ($urandom_range(0, 9) == 0) rd_app_en = ~rd_app_en;
      init_calib_complete = ($urandom_range(0, 49) != 0);
      app_rdy = ($urandom_range(0, 9) < 6);
      app_wdf_rdy = $urandom_range(0, 1);
      app_rd_data_valid = $urandom_range(0, 1);
      app_rd_data = rnd_data();
      rd_app_addr = AW'($urandom);
      wr_app_addr = AW'($urandom);
      @(negedge clk);
      ew = (m_owner == O_WR); er = (m_owner == O_RD);
      een = init_calib_complete && ((ew && wr_app_en) || (er && rd_app_en));
`ifdef DDR3_DMA_ARB_STATS_EN
      xw = m_wr_total; xr = m_rd_total;
`else
      xw = 32'd0; xr = 32'd0;
`endif
      checks++; if (grant_wr !== ew || grant_rd !== er || app_en !== een) begin
        errors++; $display("FAIL rand_arb c=%0d got gw=%b gr=%b en=%b want %b %b %b",
                           c, grant_wr, grant_rd, app_en, ew, er, een); end
      checks++; if (wr_app_rdy !== (init_calib_complete && ew && app_rdy) ||
                    wr_app_wdf_rdy !== (init_calib_complete && ew && app_wdf_rdy) ||
                    rd_app_rdy !== (init_calib_complete && er && app_rdy)) begin
        errors++; $display("FAIL rand_ready c=%0d got %b%b%b", c, wr_app_rdy, wr_app_wdf_rdy, rd_app_rdy); end
      checks++; if ((er && app_cmd !== 3'b001) || (ew && app_cmd !== 3'b000) ||
                    (er && app_addr !== rd_app_addr) || (ew && app_addr !== wr_app_addr)) begin
        errors++; $display("FAIL rand_cmd c=%0d got cmd=%0d addr=%h", c, app_cmd, app_addr); end
      checks++; if (rd_app_rd_data !== app_rd_data || rd_app_rd_data_valid !== app_rd_data_valid) begin
        errors++; $display("FAIL rand_rdret c=%0d got valid=%b want %b", c, rd_app_rd_data_valid, app_rd_data_valid); end
      checks++; if (wr_cmd_cnt !== xw || rd_cmd_cnt !== xr) begin
        errors++; $display("FAIL rand_counters c=%0d got %0d/%0d want %0d/%0d", c, wr_cmd_cnt, rd_cmd_cnt, xw, xr); end
      model_step();
      next_cycle();
    end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    wr_app_en = 1'b1; app_rdy = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    checks++; if (app_en !== 1'b1 || grant_wr !== 1'b1) begin
      errors++; $display("FAIL midburst_pre got en=%b gw=%b want 1 1", app_en, grant_wr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (app_en !== 1'b0 || grant_wr !== 1'b0 || wr_app_rdy !== 1'b0) begin
      errors++; $display("FAIL midburst_async got en=%b gw=%b rdy=%b want 0 0 0", app_en, grant_wr, wr_app_rdy); end
    @(posedge clk);
    #1;
    checks++; if (wr_cmd_cnt !== 32'd0 || app_en !== 1'b0) begin
      errors++; $display("FAIL midburst_cnt got cnt=%0d en=%b want 0 0", wr_cmd_cnt, app_en); end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_stats();
`ifdef DDR3_DMA_ARB_STATS_EN
    do_reset();
    wr_app_en = 1'b1;
    next_cycle();
    force dut.r_wr_cmd_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_wr_cmd_cnt;
    checks++; if (wr_cmd_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL stats_preload got %h want ffffffff", wr_cmd_cnt); end
    app_rdy = 1'b1;
    @(negedge clk);
    checks++; if (app_en !== 1'b1) begin
      errors++; $display("FAIL stats_beat got en=%b want 1", app_en); end
    next_cycle();
    app_rdy = 1'b0;
    checks++; if (wr_cmd_cnt !== 32'd0 || rd_cmd_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_wrap got %h/%h want 0/0", wr_cmd_cnt, rd_cmd_cnt); end
`else
    do_reset();
    wr_app_en = 1'b1; app_rdy = 1'b1;
    repeat (6) next_cycle();
    checks++; if (wr_cmd_cnt !== 32'd0 || rd_cmd_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_tied got %0d/%0d want 0/0", wr_cmd_cnt, rd_cmd_cnt); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_calib_gate();
    test_tie_pattern();
    test_single_stream();
    test_rdy_toggle();
    test_random();
    test_reset_midburst();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
